// File: rtl/config_pkg.sv
// Shared types and constants for the ALU command sequencer.
// ALU op encoding, packet opcode bytes, header length, FSM states.
package config_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_MUL = 2'd1,
        ALU_DIV = 2'd2
    } alu_op_e;

    typedef enum logic [3:0] {
        IDLE,
        RSVD,
        LEN_LO,
        LEN_HI,
        ECHO,
        LOAD,
        ALU_REQ,
        ALU_WAIT,
        TX_RES,
        DRAIN
    } seq_state_e;

    localparam logic [7:0] OPC_ECHO = 8'hEC;
    localparam logic [7:0] OPC_ADD  = 8'hAD;
    localparam logic [7:0] OPC_MUL  = 8'h4D;
    localparam logic [7:0] OPC_DIV  = 8'h4E;

    localparam logic [15:0] HDR_LEN = 16'd4;

    function automatic logic is_alu_opc(input logic [7:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

    function automatic alu_op_e opc_to_alu(input logic [7:0] opc);
        alu_op_e op;
        case (opc)
            OPC_MUL: op = ALU_MUL;
            OPC_DIV: op = ALU_DIV;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_word_packer.sv
// Little-endian operand assembler: collects OPERAND_W/8 bytes into a word.
// Ports: clr_i restarts assembly, en_i/byte_i accept a byte, done_o/word_o flag the completed word.
module alu_word_packer #(
    parameter int OPERAND_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [7:0]           byte_i,
    output logic                 done_o,
    output logic [OPERAND_W-1:0] word_o
);

    localparam int BYTES = OPERAND_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OPERAND_W-1:0] sr_q, sr_d;

    // word_o already includes the byte being accepted this cycle
    assign word_o = sr_q | (OPERAND_W'(byte_i) << {idx_q, 3'b000});
    assign done_o = en_i && (idx_q == LAST);

    always_comb begin
        idx_d = idx_q;
        sr_d  = sr_q;
        if (clr_i) begin
            idx_d = '0;
            sr_d  = '0;
        end else if (en_i) begin
            if (done_o) begin
                idx_d = '0;
                sr_d  = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                sr_d  = word_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
            sr_q  <= '0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Parses UART command packets, folds operands through a shared ALU, returns results.
// Ports: rx_* byte stream in, tx_* byte stream out, alu_* request/response, err_o pulse.
module alu_cmd_sequencer
    import config_pkg::*;
#(
    parameter int OPERAND_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output alu_op_e              alu_op_o,
    output logic [OPERAND_W-1:0] alu_a_o,
    output logic [OPERAND_W-1:0] alu_b_o,
    output logic                 alu_valid_o,
    input  logic                 alu_ready_i,
    input  logic [OPERAND_W-1:0] alu_result_i,
    input  logic                 alu_result_valid_i,
    output logic                 err_o
);

    localparam logic [15:0] BYTES16 = 16'(OPERAND_W / 8);

    seq_state_e           state_q, state_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [OPERAND_W-1:0] acc_q, acc_d;
    logic                 first_q, first_d;
    logic [OPERAND_W-1:0] alu_a_q, alu_a_d;
    logic [OPERAND_W-1:0] alu_b_q, alu_b_d;
    alu_op_e              alu_op_q, alu_op_d;
    logic                 err_q, err_d;

    logic                 rx_hs, tx_hs;
    logic [15:0]          len_w, pay_w;
    logic                 pk_clr, pk_en, pk_done;
    logic [OPERAND_W-1:0] pk_word;

    // Echo forwards rx straight to tx, so rx readiness follows the sink
    assign rx_ready_o = rst_ni && ((state_q == IDLE) || (state_q == RSVD)
                     || (state_q == LEN_LO) || (state_q == LEN_HI)
                     || (state_q == LOAD) || (state_q == DRAIN)
                     || ((state_q == ECHO) && tx_ready_i));

    assign tx_valid_o = (state_q == TX_RES) || ((state_q == ECHO) && rx_valid_i);
    assign tx_data_o  = (state_q == TX_RES) ? acc_q[7:0]
                      : (state_q == ECHO)   ? rx_data_i : 8'h00;

    assign rx_hs = rx_valid_i && rx_ready_o;
    assign tx_hs = tx_valid_o && tx_ready_i;

    assign alu_valid_o = (state_q == ALU_REQ);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign err_o       = err_q;

    assign len_w = {rx_data_i, len_lo_q};
    assign pay_w = len_w - HDR_LEN;
    assign pk_en = (state_q == LOAD) && rx_hs;

    alu_word_packer #(
        .OPERAND_W(OPERAND_W)
    ) u_packer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (pk_clr),
        .en_i  (pk_en),
        .byte_i(rx_data_i),
        .done_o(pk_done),
        .word_o(pk_word)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        len_lo_d = len_lo_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        first_d  = first_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        err_d    = 1'b0;
        pk_clr   = 1'b0;
        case (state_q)
            IDLE: if (rx_hs) begin
                opcode_d = rx_data_i;
                state_d  = RSVD;
            end
            RSVD: if (rx_hs) state_d = LEN_LO;
            LEN_LO: if (rx_hs) begin
                len_lo_d = rx_data_i;
                state_d  = LEN_HI;
            end
            LEN_HI: if (rx_hs) begin
                cnt_d = pay_w;
                if (len_w <= HDR_LEN) begin
                    state_d = IDLE;
                end else if (opcode_q == OPC_ECHO) begin
                    state_d = ECHO;
                end else if (is_alu_opc(opcode_q)
                             && (pay_w % BYTES16) == 16'd0) begin
                    state_d  = LOAD;
                    first_d  = 1'b1;
                    pk_clr   = 1'b1;
                    alu_op_d = opc_to_alu(opcode_q);
                end else begin
                    state_d = DRAIN;
                    err_d   = 1'b1;
                end
            end
            ECHO: if (rx_hs) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = IDLE;
            end
            LOAD: if (rx_hs) begin
                cnt_d = cnt_q - 16'd1;
                if (pk_done) begin
                    if (first_q) begin
                        acc_d   = pk_word;
                        first_d = 1'b0;
                        // single operand: result is the operand itself
                        if (cnt_q == 16'd1) begin
                            state_d = TX_RES;
                            cnt_d   = BYTES16;
                        end
                    end else begin
                        alu_a_d = acc_q;
                        alu_b_d = pk_word;
                        state_d = ALU_REQ;
                    end
                end
            end
            ALU_REQ: if (alu_ready_i) state_d = ALU_WAIT;
            ALU_WAIT: if (alu_result_valid_i) begin
                acc_d = alu_result_i;
                if (cnt_q == 16'd0) begin
                    state_d = TX_RES;
                    cnt_d   = BYTES16;
                end else begin
                    state_d = LOAD;
                end
            end
            // cnt_q is reused as the remaining result byte count
            TX_RES: if (tx_hs) begin
                acc_d = acc_q >> 8;
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = IDLE;
            end
            DRAIN: if (rx_hs) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            opcode_q <= 8'h00;
            len_lo_q <= 8'h00;
            cnt_q    <= 16'd0;
            acc_q    <= '0;
            first_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_ADD;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            len_lo_q <= len_lo_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            first_q  <= first_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            err_q    <= err_d;
        end
    end

endmodule
